// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_pkg: shared widths, zero-register address and grant encoding for the writeback arbiter.
package regfile_pkg;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int NREG   = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] REG_ZERO = '0;
    typedef enum logic [1:0] {GNT_NONE, GNT_A, GNT_B} gnt_e;
endpackage

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// regfile_scoreboard: pending-write busy vector with set/clear ports and two combinational check ports.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int SB_ADDR_W = ADDR_W,
    parameter int SB_NREG   = NREG
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_set_en,
    input  logic [SB_ADDR_W-1:0] i_set_addr,
    input  logic                 i_clr_en,
    input  logic [SB_ADDR_W-1:0] i_clr_addr,
    input  logic [SB_ADDR_W-1:0] i_chk_addr1,
    input  logic [SB_ADDR_W-1:0] i_chk_addr2,
    output logic                 o_chk_busy1,
    output logic                 o_chk_busy2
);
    logic [SB_NREG-1:0] r_busy;
    logic [SB_NREG-1:0] w_busy_nxt;

    // Clear is applied before set so a same-edge reservation of the same register survives.
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_clr_en) w_busy_nxt[i_clr_addr] = 1'b0;
        if (i_set_en) w_busy_nxt[i_set_addr] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_busy <= '0;
        else      r_busy <= w_busy_nxt;
    end

    assign o_chk_busy1 = (i_chk_addr1 != SB_ADDR_W'(REG_ZERO)) && r_busy[i_chk_addr1];
    assign o_chk_busy2 = (i_chk_addr2 != SB_ADDR_W'(REG_ZERO)) && r_busy[i_chk_addr2];
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: two-source writeback arbiter with starvation guard and pending-write scoreboard.
// Optional REGFILE_WB_SKID_EN adds a one-entry skid buffer on port A.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int P_ADDR_W   = ADDR_W,
    parameter int P_DATA_W   = DATA_W,
    parameter int P_NREG     = NREG,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [P_ADDR_W-1:0] a_waddr,
    input  logic [P_DATA_W-1:0] a_wdata,
    input  logic                b_valid,
    output logic                b_ready,
    input  logic [P_ADDR_W-1:0] b_waddr,
    input  logic [P_DATA_W-1:0] b_wdata,
    input  logic                rsv_valid,
    input  logic [P_ADDR_W-1:0] rsv_addr,
    input  logic [P_ADDR_W-1:0] chk_addr1,
    input  logic [P_ADDR_W-1:0] chk_addr2,
    output logic                chk_busy1,
    output logic                chk_busy2,
    output logic                we,
    output logic [P_ADDR_W-1:0] waddr,
    output logic [P_DATA_W-1:0] wdata
);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic                r_we;
    logic [P_ADDR_W-1:0] r_waddr;
    logic [P_DATA_W-1:0] r_wdata;
    logic [3:0]          r_starve;
    gnt_e                w_gnt;
    logic                w_ea_valid;
    logic [P_ADDR_W-1:0] w_ea_addr;
    logic [P_DATA_W-1:0] w_ea_data;
    logic                w_xfer;
    logic [P_ADDR_W-1:0] w_addr;
    logic [P_DATA_W-1:0] w_data;

`ifdef REGFILE_WB_SKID_EN
    logic                r_skid_full;
    logic [P_ADDR_W-1:0] r_skid_addr;
    logic [P_DATA_W-1:0] r_skid_data;

    // A held skid entry is older than the live a_* request, so it competes first.
    assign w_ea_valid = r_skid_full || a_valid;
    assign w_ea_addr  = r_skid_full ? r_skid_addr : a_waddr;
    assign w_ea_data  = r_skid_full ? r_skid_data : a_wdata;
    assign a_ready    = rst && !r_skid_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_skid_full <= 1'b0;
            r_skid_addr <= '0;
            r_skid_data <= '0;
        end else if (r_skid_full) begin
            if (w_gnt == GNT_A) r_skid_full <= 1'b0;
        end else if (a_valid && w_gnt == GNT_B) begin
            r_skid_full <= 1'b1;
            r_skid_addr <= a_waddr;
            r_skid_data <= a_wdata;
        end
    end
`else
    assign w_ea_valid = a_valid;
    assign w_ea_addr  = a_waddr;
    assign w_ea_data  = a_wdata;
    assign a_ready    = rst && w_gnt == GNT_A;
`endif

    always_comb begin
        w_gnt = (b_valid && (!w_ea_valid || r_starve == STARVE_LIM)) ? GNT_B :
                w_ea_valid ? GNT_A : GNT_NONE;
    end

    assign b_ready = rst && w_gnt == GNT_B;
    assign w_xfer  = w_gnt != GNT_NONE;
    assign w_addr  = (w_gnt == GNT_B) ? b_waddr : w_ea_addr;
    assign w_data  = (w_gnt == GNT_B) ? b_wdata : w_ea_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we     <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
            r_starve <= '0;
        end else begin
            r_we     <= w_xfer && w_addr != P_ADDR_W'(REG_ZERO);
            if (w_xfer) begin
                r_waddr <= w_addr;
                r_wdata <= w_data;
            end
            r_starve <= (!b_valid || w_gnt == GNT_B) ? 4'd0 :
                        (w_gnt == GNT_A && r_starve != STARVE_LIM) ? r_starve + 4'd1 : r_starve;
        end
    end

    assign we    = r_we;
    assign waddr = r_waddr;
    assign wdata = r_wdata;

    regfile_scoreboard #(.SB_ADDR_W(P_ADDR_W), .SB_NREG(P_NREG)) u_sb (
        .clk         (clk),
        .rst         (rst),
        .i_set_en    (rsv_valid),
        .i_set_addr  (rsv_addr),
        .i_clr_en    (b_ready),
        .i_clr_addr  (b_waddr),
        .i_chk_addr1 (chk_addr1),
        .i_chk_addr2 (chk_addr2),
        .o_chk_busy1 (chk_busy1),
        .o_chk_busy2 (chk_busy2)
    );
endmodule
